inv_delay_meas_ctrl: RTL and testbench

//  Sequencer for on-chip inverter/inverter-chain propagation-delay measurement.

---
 rtl/inv_delay_meas_ctrl_if.sv | 31 +++
 rtl/inv_delay_meas_ctrl.sv | 159 +++++++++++++++
 tb/tb_inv_delay_meas_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/inv_delay_meas_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : inv_delay_meas_ctrl_if
// Brief   : Control/status and chain-macro signals of the delay sequencer.
//           slave  = the sequencer itself.
//           master = register bank plus chain macro (bench side).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
interface inv_delay_meas_ctrl_if #(
  parameter int CNT_W = 12
);
  logic             start;
  logic             chain_out;
  logic             launch;
  logic             busy;
  logic             done;
  logic             timeout_err;
  logic [CNT_W-1:0] delay_last;
  logic [CNT_W-1:0] delay_avg;

  modport master (
    output start, chain_out,
    input  launch, busy, done, timeout_err, delay_last, delay_avg
  );

  modport slave (
    input  start, chain_out,
    output launch, busy, done, timeout_err, delay_last, delay_avg
  );
endinterface
`default_nettype wire

// File: rtl/inv_delay_meas_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : inv_delay_meas_ctrl
// Brief   : Inverter-chain propagation-delay sequencer. Precharges the chain,
//           fires a falling edge, counts CLK cycles until the synchronised
//           chain output rises, and averages 2^AVG_LOG2 measurements.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module inv_delay_meas_ctrl #(
  parameter int CNT_W    = 12,
  parameter int AVG_LOG2 = 3,
  parameter int SETTLE   = 16,
  parameter int TIMEOUT  = 4095
) (
  input wire logic             CLK,
  input wire logic             RESET_B,
  inv_delay_meas_ctrl_if.slave bus
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_FIRE = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_ACC  = 3'd4;
  localparam logic [2:0] ST_END  = 3'd5;

  localparam int               ACC_W       = CNT_W + AVG_LOG2;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  // Two-flop synchroniser latency, removed from every raw count.
  localparam logic [CNT_W-1:0] SYNC_LAT    = CNT_W'(2);
  localparam logic [AVG_LOG2:0] LAST_IDX   = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

  logic [2:0]        r_state;
  logic [1:0]        r_sync;
  logic [CNT_W-1:0]  r_cnt;
  logic [ACC_W-1:0]  r_acc;
  logic [AVG_LOG2:0] r_idx;
  logic              r_launch;
  logic              r_busy;
  logic              r_done;
  logic              r_terr;
  logic [CNT_W-1:0]  r_delay_last;
  logic [CNT_W-1:0]  r_delay_avg;

  logic              w_out_s;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [CNT_W-1:0]  w_delay;
  logic [ACC_W-1:0]  w_acc_sum;
  logic [CNT_W-1:0]  w_avg;

  assign w_out_s   = r_sync[1];
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  // Counts at or below the synchroniser latency clamp to zero delay.
  assign w_delay   = (r_cnt > SYNC_LAT) ? (r_cnt - SYNC_LAT) : '0;
  assign w_acc_sum = r_acc + ACC_W'(w_delay);
  // Truncating divide by 2^AVG_LOG2.
  assign w_avg     = r_acc[ACC_W-1:AVG_LOG2];

  // Bring the asynchronous chain output into the CLK domain.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) r_sync <= '0;
    else          r_sync <= {r_sync[0], bus.chain_out};
  end

  // Measurement sequencer: precharge, fire, count, accumulate, report.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_idx        <= '0;
      r_launch     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_terr       <= 1'b0;
      r_delay_last <= '0;
      r_delay_avg  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_launch <= 1'b0;
          if (bus.start) begin
            r_state  <= ST_PRE;
            r_launch <= 1'b1;
            r_busy   <= 1'b1;
            r_terr   <= 1'b0;
            r_acc    <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
          end
        end
        ST_PRE: begin
          if (r_cnt == SETTLE_LAST) begin
            if (!w_out_s) begin
              r_state  <= ST_FIRE;
              r_launch <= 1'b0;
            end else begin
              // Chain output did not precharge low: abort without firing.
              r_terr  <= 1'b1;
              r_done  <= 1'b1;
              r_state <= ST_END;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_FIRE: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_cnt <= w_cnt_inc;
          if (w_out_s) begin
            r_state <= ST_ACC;
          end else if (w_cnt_inc == TIMEOUT_CNT) begin
            r_terr  <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_END;
          end
        end
        ST_ACC: begin
          r_delay_last <= w_delay;
          r_acc        <= w_acc_sum;
          r_idx        <= r_idx + (AVG_LOG2 + 1)'(1);
          if (r_idx == LAST_IDX) begin
            r_done  <= 1'b1;
            r_state <= ST_END;
          end else begin
            r_launch <= 1'b1;
            r_cnt    <= '0;
            r_state  <= ST_PRE;
          end
        end
        ST_END: begin
          r_busy   <= 1'b0;
          r_launch <= 1'b0;
          if (!r_terr) r_delay_avg <= w_avg;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_busy   <= 1'b0;
          r_launch <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.launch      = r_launch;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.timeout_err = r_terr;
  assign bus.delay_last  = r_delay_last;
  assign bus.delay_avg   = r_delay_avg;

endmodule
`default_nettype wire

// File: tb/tb_inv_delay_meas_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_inv_delay_meas_ctrl
// Brief   : Directed self-checking bench for inv_delay_meas_ctrl with a
//           behavioural inverter-chain model of programmable delay.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_inv_delay_meas_ctrl;

  localparam int CNT_W    = 12;
  localparam int M_STUCK0 = 0;
  localparam int M_STUCK1 = 1;
  localparam int M_NORMAL = 2;

  logic CLK     = 1'b0;
  logic RESET_B = 1'b0;

  int n_checks  = 0;
  int n_fail    = 0;
  int mode      = M_STUCK0;
  int model_idx = 0;
  int dly [8];
  int bc, dc, lf;

  inv_delay_meas_ctrl_if #(.CNT_W(CNT_W)) bus ();

  inv_delay_meas_ctrl #(
    .CNT_W   (CNT_W),
    .AVG_LOG2(3),
    .SETTLE  (16),
    .TIMEOUT (4095)
  ) dut (
    .CLK    (CLK),
    .RESET_B(RESET_B),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  // Chain model: output drops when launch rises (precharge) and rises
  // dly[k] CLK edges after launch falls.
  initial begin : chain_model
    logic launch_q;
    int   cd;
    bit   armed;
    launch_q      = 1'b0;
    cd            = 0;
    armed         = 1'b0;
    bus.chain_out = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      case (mode)
        M_STUCK0: begin bus.chain_out = 1'b0; armed = 1'b0; end
        M_STUCK1: begin bus.chain_out = 1'b1; armed = 1'b0; end
        default: begin
          if (bus.launch && !launch_q) begin
            bus.chain_out = 1'b0;
            armed         = 1'b0;
          end else if (!bus.launch && launch_q) begin
            cd        = dly[model_idx % 8];
            model_idx = model_idx + 1;
            armed     = 1'b1;
          end else if (armed) begin
            cd = cd - 1;
            if (cd == 0) begin
              bus.chain_out = 1'b1;
              armed         = 1'b0;
            end
          end
        end
      endcase
      launch_q = bus.launch;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_launch"}, 32'(bus.launch), 0);
    check({tag, "_busy"},   32'(bus.busy), 0);
    check({tag, "_done"},   32'(bus.done), 0);
    check({tag, "_terr"},   32'(bus.timeout_err), 0);
    check({tag, "_last"},   32'(bus.delay_last), 0);
    check({tag, "_avg"},    32'(bus.delay_avg), 0);
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
  endtask

  // Samples on falling edges while busy; optionally pokes start mid-run and
  // in the END cycle.
  task automatic wait_run(input int limit, input bit poke,
                          output int busy_cyc, output int done_cnt, output int launch_falls);
    logic lq;
    busy_cyc     = 0;
    done_cnt     = 0;
    launch_falls = 0;
    lq           = bus.launch;
    while (bus.busy && busy_cyc < limit) begin
      busy_cyc++;
      if (bus.done) done_cnt++;
      if (lq && !bus.launch) launch_falls++;
      lq = bus.launch;
      if (poke) bus.start = (busy_cyc == 3) || bus.done;
      @(negedge CLK);
    end
    bus.start = 1'b0;
    check("busy_dropped", 32'(bus.busy), 0);
  endtask

  task automatic run_normal(input string tag, input int d0, input int d1, input int d2, input int d3,
                            input int d4, input int d5, input int d6, input int d7,
                            input int exp_busy, input int exp_last, input int exp_avg);
    dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
    dly[4] = d4; dly[5] = d5; dly[6] = d6; dly[7] = d7;
    model_idx = 0;
    mode      = M_NORMAL;
    pulse_start();
    wait_run(2000, 1'b0, bc, dc, lf);
    check({tag, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
    check({tag, "_done_count"},  32'(dc), 1);
    check({tag, "_delay_last"},  32'(bus.delay_last), 32'(exp_last));
    check({tag, "_delay_avg"},   32'(bus.delay_avg), 32'(exp_avg));
    check({tag, "_terr"},        32'(bus.timeout_err), 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bus.start = 1'b0;

    // 1: reset state and idle without start
    @(negedge CLK);
    check_all_zero("rst");
    @(negedge CLK);
    RESET_B = 1'b1;
    repeat (6) @(negedge CLK);
    check_all_zero("idle");

    // 2: constant delay 5 -> each measurement 16+1+7+1 = 25 cycles, +1 END
    run_normal("d5", 5, 5, 5, 5, 5, 5, 5, 5, 201, 5, 5);

    // 3: averaging; 40 -> 5, and 25 -> 3 with truncation
    run_normal("mix46", 4, 4, 4, 4, 6, 6, 6, 6, 201, 6, 5);
    run_normal("trunc", 3, 3, 3, 3, 3, 3, 3, 4, 186, 4, 3);

    // 4: chain stuck low -> WAIT times out at 4095
    mode = M_STUCK0;
    pulse_start();
    wait_run(6000, 1'b0, bc, dc, lf);
    check("to_busy_cycles", 32'(bc), 32'(16 + 1 + 4095 + 1));
    check("to_done_count",  32'(dc), 1);
    check("to_terr",        32'(bus.timeout_err), 1);
    check("to_delay_avg",   32'(bus.delay_avg), 3);
    check("to_delay_last",  32'(bus.delay_last), 4);
    repeat (3) @(negedge CLK);
    check("to_terr_sticky", 32'(bus.timeout_err), 1);

    // 5: chain stuck high -> abort at end of PRE; start cleared the flag
    mode = M_STUCK1;
    pulse_start();
    check("accept_clears_terr", 32'(bus.timeout_err), 0);
    wait_run(100, 1'b1, bc, dc, lf);
    check("s1_busy_cycles",  32'(bc), 17);
    check("s1_done_count",   32'(dc), 1);
    check("s1_launch_falls", 32'(lf), 0);
    check("s1_terr",         32'(bus.timeout_err), 1);
    check("s1_delay_avg",    32'(bus.delay_avg), 3);
    repeat (4) @(negedge CLK);
    check("end_start_ignored", 32'(bus.busy), 0);

    // 6: asynchronous reset in the middle of WAIT
    mode = M_STUCK0;
    pulse_start();
    repeat (25) @(negedge CLK);
    check("pre_rst_busy", 32'(bus.busy), 1);
    #2;
    RESET_B = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge CLK);
    RESET_B = 1'b1;
    repeat (3) @(negedge CLK);
    check_all_zero("post_rst");
    run_normal("d2", 2, 2, 2, 2, 2, 2, 2, 2, 177, 2, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
